score_display: RTL and testbench



---
 rtl/score_pkg.sv | 48 ++++
 rtl/score_display_seg7_encoder.sv | 16 +
 rtl/score_display.sv | 184 ++++++++++++++++++
 tb/tb_score_display.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared definitions for the score display: FSM states, segment patterns,
// conversion length and the digit-to-segment helper.
package score_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONV,
      S_LOAD
   } state_e;

   // Active-high patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   // 7 shift edges plus one alignment edge
   localparam int unsigned CONV_CYCLES = 8;

   function automatic logic [6:0] seg_encode(input logic [3:0] digit,
                                             input logic       blank,
                                             input logic       active_low);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      if (blank) seg = SEG_BLANK;
      return active_low ? ~seg : seg;
   endfunction

endpackage

// File: rtl/score_display_seg7_encoder.sv
// Combinational BCD digit to 7-segment encoder with blanking and polarity.
module seg7_encoder
   import score_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic [3:0] digit_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = seg_encode(digit_i, blank_i, ACTIVE_LOW);
   end

endmodule

// File: rtl/score_display.sv
// Current/best score tracker with sequential double-dabble conversion and
// registered 7-segment outputs for both scores.
module score_display
   import score_pkg::*;
#(
   parameter int unsigned SCORE_W        = 8,
   parameter int unsigned MAX_SCORE      = 99,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          BLANK_LEADING  = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [SCORE_W-1:0] pun,
   input  logic               pun_valid,
   input  logic               clr_max,
   output logic               busy,
   output logic               new_max,
   output logic [6:0]         apun_t,
   output logic [6:0]         apun_u,
   output logic [6:0]         mpun_t,
   output logic [6:0]         mpun_u
);

   localparam logic [SCORE_W-1:0] MAX_W = SCORE_W'(MAX_SCORE);
   localparam logic [6:0] RST_T = seg_encode(4'd0, BLANK_LEADING, SEG_ACTIVE_LOW);
   localparam logic [6:0] RST_U = seg_encode(4'd0, 1'b0, SEG_ACTIVE_LOW);

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [14:0] sr_q, sr_d;
   logic [6:0]  val_q, val_d;
   logic        cand_q, cand_d;
   logic [6:0]  max_q, max_d;
   logic        pend_q, pend_d;
   logic [6:0]  pend_val_q, pend_val_d;
   logic        clrp_q, clrp_d;
   logic        new_max_q, new_max_d;
   logic [6:0]  apun_t_q, apun_u_q, mpun_t_q, mpun_u_q;

   logic        load_cur, load_max, clr_seg, start;
   logic [6:0]  start_val, pun_sat;
   logic [3:0]  mdig_t, mdig_u;
   logic [6:0]  enc_at, enc_au, enc_mt, enc_mu;

   function automatic logic [14:0] dd_step(input logic [14:0] s);
      logic [3:0] t, u;
      t = s[14:11];
      u = s[10:7];
      if (t >= 4'd5) t = t + 4'd3;
      if (u >= 4'd5) u = u + 4'd3;
      return {t, u, s[6:0]} << 1;
   endfunction

   always_comb begin
      pun_sat = (pun > MAX_W) ? MAX_W[6:0] : pun[6:0];
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sr_d       = sr_q;
      val_d      = val_q;
      cand_d     = cand_q;
      max_d      = max_q;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      clrp_d     = clrp_q;
      new_max_d  = 1'b0;
      load_cur   = 1'b0;
      load_max   = 1'b0;
      clr_seg    = 1'b0;
      start      = 1'b0;
      start_val  = '0;
      case (state_q)
         S_IDLE: begin
            if (clr_max) begin
               max_d   = '0;
               clr_seg = 1'b1;
            end
            if (pun_valid) begin
               start     = 1'b1;
               start_val = pun_sat;
            end
         end
         S_CONV: begin
            if (pun_valid) begin
               pend_d     = 1'b1;
               pend_val_d = pun_sat;
            end
            if (clr_max) clrp_d = 1'b1;
            if (cnt_q == 3'(CONV_CYCLES - 1)) state_d = S_LOAD;
            else sr_d = dd_step(sr_q);
            cnt_d = cnt_q + 3'd1;
         end
         S_LOAD: begin
            load_cur = 1'b1;
            clrp_d   = 1'b0;
            state_d  = S_IDLE;
            if (clrp_q || clr_max) begin
               max_d   = '0;
               clr_seg = 1'b1;
            end else if (cand_q) begin
               max_d     = val_q;
               load_max  = 1'b1;
               new_max_d = 1'b1;
            end
            // a strobe on the LOAD edge itself behaves as a just-written pending value
            if (pend_q || pun_valid) begin
               start     = 1'b1;
               start_val = pun_valid ? pun_sat : pend_val_q;
               pend_d    = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (start) begin
         sr_d    = {8'd0, start_val};
         val_d   = start_val;
         cand_d  = (start_val > max_d);
         cnt_d   = '0;
         state_d = S_CONV;
      end
   end

   always_comb begin
      mdig_t = clr_seg ? 4'd0 : sr_q[14:11];
      mdig_u = clr_seg ? 4'd0 : sr_q[10:7];
   end

   seg7_encoder #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc_at (
      .digit_i(sr_q[14:11]), .blank_i(BLANK_LEADING && (sr_q[14:11] == 4'd0)), .seg_o(enc_at));
   seg7_encoder #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc_au (
      .digit_i(sr_q[10:7]), .blank_i(1'b0), .seg_o(enc_au));
   seg7_encoder #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc_mt (
      .digit_i(mdig_t), .blank_i(BLANK_LEADING && (mdig_t == 4'd0)), .seg_o(enc_mt));
   seg7_encoder #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc_mu (
      .digit_i(mdig_u), .blank_i(1'b0), .seg_o(enc_mu));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         sr_q       <= '0;
         val_q      <= '0;
         cand_q     <= 1'b0;
         max_q      <= '0;
         pend_q     <= 1'b0;
         pend_val_q <= '0;
         clrp_q     <= 1'b0;
         new_max_q  <= 1'b0;
         apun_t_q   <= RST_T;
         apun_u_q   <= RST_U;
         mpun_t_q   <= RST_T;
         mpun_u_q   <= RST_U;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sr_q       <= sr_d;
         val_q      <= val_d;
         cand_q     <= cand_d;
         max_q      <= max_d;
         pend_q     <= pend_d;
         pend_val_q <= pend_val_d;
         clrp_q     <= clrp_d;
         new_max_q  <= new_max_d;
         if (load_cur) begin
            apun_t_q <= enc_at;
            apun_u_q <= enc_au;
         end
         if (clr_seg || load_max) begin
            mpun_t_q <= enc_mt;
            mpun_u_q <= enc_mu;
         end
      end
   end

   assign busy    = (state_q != S_IDLE);
   assign new_max = new_max_q;
   assign apun_t  = apun_t_q;
   assign apun_u  = apun_u_q;
   assign mpun_t  = mpun_t_q;
   assign mpun_u  = mpun_u_q;

endmodule

// File: tb/tb_score_display.sv
// Directed scoreboard bench for score_display with default parameters
// (8-bit score, ceiling 99, active-low segments, leading-zero blanking).
module tb_score_display;

   typedef struct {
      logic [6:0] at;
      logic [6:0] au;
      logic [6:0] mt;
      logic [6:0] mu;
      logic       nm;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] pun = '0;
   logic       pun_valid = 1'b0;
   logic       clr_max = 1'b0;
   logic       busy, new_max;
   logic [6:0] apun_t, apun_u, mpun_t, mpun_u;

   logic [6:0] AL [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
   localparam logic [6:0] BLANK = 7'b1111111;

   int   n_assert = 0;
   int   n_fail = 0;
   exp_t sb[$];
   int   best = 0;
   logic [6:0] m_mt = 7'b1111111;
   logic [6:0] m_mu = 7'b1000000;
   logic saw50 = 1'b0;
   logic watch50 = 1'b0;

   score_display dut (
      .clk(clk), .reset(reset), .pun(pun), .pun_valid(pun_valid), .clr_max(clr_max),
      .busy(busy), .new_max(new_max), .apun_t(apun_t), .apun_u(apun_u),
      .mpun_t(mpun_t), .mpun_u(mpun_u));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (watch50 && apun_t === AL[5]) saw50 = 1'b1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Model of one completed conversion; updates the bench's own best score
   function automatic exp_t model(input int v, input bit clr);
      exp_t e;
      int   s;
      s = (v > 99) ? 99 : v;
      e.at = (s / 10 == 0) ? BLANK : AL[s / 10];
      e.au = AL[s % 10];
      e.nm = 1'b0;
      if (clr) begin
         best = 0;
         m_mt = BLANK;
         m_mu = AL[0];
      end else if (s > best) begin
         best = s;
         m_mt = e.at;
         m_mu = e.au;
         e.nm = 1'b1;
      end
      e.mt = m_mt;
      e.mu = m_mu;
      return e;
   endfunction

   task automatic strobe(input int v, input bit clr_during);
      sb.push_back(model(v, clr_during));
      pun = 8'(v);
      pun_valid = 1'b1;
      tick();
      pun_valid = 1'b0;
   endtask

   task automatic compare_head(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 7'd0, 7'd1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_apun_t"}, apun_t, e.at);
         chk({tag, "_apun_u"}, apun_u, e.au);
         chk({tag, "_mpun_t"}, mpun_t, e.mt);
         chk({tag, "_mpun_u"}, mpun_u, e.mu);
         chk({tag, "_new_max"}, {6'd0, new_max}, {6'd0, e.nm});
      end
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 40 && busy === 1'b1; i++) tick();
      chk({tag, "_timeout"}, {6'd0, busy}, 7'd0);
      compare_head(tag);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_apun_t"}, apun_t, BLANK);
      chk({tag, "_apun_u"}, apun_u, AL[0]);
      chk({tag, "_mpun_t"}, mpun_t, BLANK);
      chk({tag, "_mpun_u"}, mpun_u, AL[0]);
      chk({tag, "_busy"}, {6'd0, busy}, 7'd0);
      chk({tag, "_new_max"}, {6'd0, new_max}, 7'd0);
   endtask

   initial begin
      tick();
      tick();
      reset = 1'b0;
      check_reset_state("reset");

      // 37: exact latency of busy and of the loaded digits
      strobe(37, 1'b0);
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("lat_busy_%0d", i), {6'd0, busy}, 7'd1);
         tick();
      end
      chk("lat_busy_done", {6'd0, busy}, 7'd0);
      compare_head("s37");
      tick();
      chk("s37_pulse_end", {6'd0, new_max}, 7'd0);

      strobe(12, 1'b0);
      wait_done("s12");
      strobe(37, 1'b0);
      wait_done("s37_equal");
      strobe(200, 1'b0);
      wait_done("s200_sat");
      tick();
      chk("s200_pulse_end", {6'd0, new_max}, 7'd0);

      // clear best in IDLE
      clr_max = 1'b1;
      tick();
      clr_max = 1'b0;
      void'(model(0, 1'b1));
      chk("clr_idle_mpun_t", mpun_t, BLANK);
      chk("clr_idle_mpun_u", mpun_u, AL[0]);

      // pending register: 50 overwritten by 60
      watch50 = 1'b1;
      strobe(40, 1'b0);
      tick();
      tick();
      pun = 8'd50;
      pun_valid = 1'b1;
      tick();
      pun_valid = 1'b0;
      tick();
      pun = 8'd60;
      pun_valid = 1'b1;
      tick();
      pun_valid = 1'b0;
      sb.push_back(model(60, 1'b0));
      for (int i = 0; i < 4; i++) tick();
      chk("pend_busy_at_load", {6'd0, busy}, 7'd1);
      compare_head("pend40");
      wait_done("pend60");
      watch50 = 1'b0;
      chk("pend_no50", {6'd0, saw50}, 7'd0);

      // clear during conversion wins over the record update
      strobe(80, 1'b1);
      tick();
      clr_max = 1'b1;
      tick();
      clr_max = 1'b0;
      wait_done("clr_conv80");
      strobe(5, 1'b0);
      wait_done("after_clr5");

      // reset mid-conversion
      strobe(90, 1'b0);
      sb.delete();
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      best = 0;
      m_mt = BLANK;
      m_mu = AL[0];
      check_reset_state("reset_mid");
      tick();
      chk("reset_mid_idle", {6'd0, busy}, 7'd0);

      // best of 37, clear in IDLE, then 5 is a new record
      strobe(37, 1'b0);
      wait_done("r37");
      clr_max = 1'b1;
      tick();
      clr_max = 1'b0;
      void'(model(0, 1'b1));
      chk("clr2_mpun_t", mpun_t, BLANK);
      chk("clr2_mpun_u", mpun_u, AL[0]);
      strobe(5, 1'b0);
      wait_done("r5");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
